// File: rtl/exp_present_ctrl.sv
// Expansion-board presence controller: debounce, power/reset sequencing, Avalon-MM regs.
// Optional: EXP_CTRL_REMOVE_DEBOUNCE_EN debounces removal as well as insertion.
module exp_present_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETTLE_CYCLES   = 100000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        exp_pwr_en,
  output logic        exp_rst_n,
  output logic        irq
);

  typedef enum logic [2:0] {
    ST_ABSENT      = 3'd0,
    ST_DEBOUNCE    = 3'd1,
    ST_PRESENT_OFF = 3'd2,
    ST_POWER_UP    = 3'd3,
    ST_READY       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ctrl;
  logic [1:0]       r_event;
  logic [1:0]       r_mask;
  logic             w_sync;
  logic             w_auto;
  logic             w_rem;
  logic             w_inc;
  logic             w_set_ins;
  logic             w_set_rem;
  logic             w_wr;
  logic             w_present;
  logic             w_ready;
  logic [1:0]       w_evt_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_sync    = r_sync2;
  assign w_auto    = r_ctrl[0] && !r_ctrl[1];
  assign w_wr      = chipselect && !write_n;
  assign w_present = (r_state >= 3'd2);
  assign w_ready   = (r_state == ST_READY);
  assign w_unused  = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef EXP_CTRL_REMOVE_DEBOUNCE_EN
  logic [CNT_W-1:0] r_rcnt;

  // Counts consecutive low samples while the board is considered present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt <= '0;
    end else if (w_sync || !w_present || w_rem) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + CNT_W'(1);
    end
  end

  assign w_rem = !w_sync && (r_rcnt == DB_LAST);
`else
  assign w_rem = !w_sync;
`endif

  always_comb begin
    w_next    = r_state;
    w_inc     = 1'b0;
    w_set_ins = 1'b0;
    w_set_rem = 1'b0;
    case (r_state)
      ST_ABSENT: begin
        if (w_sync) w_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!w_sync) begin
          w_next = ST_ABSENT;
        end else if (r_cnt == DB_LAST) begin
          w_set_ins = 1'b1;
          w_next    = w_auto ? ST_POWER_UP : ST_PRESENT_OFF;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_PRESENT_OFF: begin
        if (w_rem) begin
          w_next    = ST_ABSENT;
          w_set_rem = 1'b1;
        end else if (w_auto) begin
          w_next = ST_POWER_UP;
        end
      end
      ST_POWER_UP: begin
        if (w_rem) begin
          w_next    = ST_ABSENT;
          w_set_rem = 1'b1;
        end else if (r_ctrl[1]) begin
          w_next = ST_PRESENT_OFF;
        end else if (r_cnt == ST_LAST) begin
          w_next = ST_READY;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_READY: begin
        if (w_rem) begin
          w_next    = ST_ABSENT;
          w_set_rem = 1'b1;
        end else if (r_ctrl[1]) begin
          w_next = ST_PRESENT_OFF;
        end
      end
      default: w_next = ST_ABSENT;
    endcase
  end

  // Counter restarts on every state change, so it never needs to wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ABSENT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_inc)        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign exp_pwr_en = (r_state == ST_POWER_UP) || (r_state == ST_READY);
  assign exp_rst_n  = (r_state == ST_READY);

  assign w_evt_clr = (w_wr && address == 2'd2) ? writedata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= 2'b00;
      r_mask  <= 2'b00;
      r_event <= 2'b00;
      irq     <= 1'b0;
    end else begin
      if (w_wr && address == 2'd1) r_ctrl <= writedata[1:0];
      if (w_wr && address == 2'd3) r_mask <= writedata[1:0];
      r_event <= (r_event & ~w_evt_clr) | {w_set_rem, w_set_ins};
      irq     <= |(r_event & r_mask);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0: w_rdata = {26'd0, r_state, w_ready, w_present, w_sync};
      2'd1: w_rdata = {30'd0, r_ctrl};
      2'd2: w_rdata = {30'd0, r_event};
      2'd3: w_rdata = {30'd0, r_mask};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

endmodule
